div_seq: RTL and testbench

- Multi-cycle radix-2 restoring divider controller for the EX stage of the 5-stage pipeline.
- Accepts a DIV/DIVU operation from EX and runs a 32-iteration shift-subtract sequence.
- Returns {remainder, quotient} for the HI/LO write.
- While busy it raises an EX-stage stall request into the pipeline stall controller. That freezes PC/IF/ID/EX, with stall vector 6'b001111.

---
 rtl/div_seq_if.sv | 28 ++
 rtl/div_seq.sv | 122 ++++++++++++
 tb/tb_div_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Divider handshake bundle between the EX stage and div_seq.
// Handshake: the EX stage holds start_i high (with operands stable) for as long as
// it owns a divide; the divider answers with a single-cycle ready_o pulse, and
// result_o is meaningful only in that cycle. stallreq_o stays high until then.
// state_o is a debug view of the controller state (0=IDLE,1=DIV_ZERO,2=DIV_ON,3=DIV_END).
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;
  logic [1:0]          state_o;

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o, state_o
  );

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o, state_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Magnitudes are divided over DATA_W shift-subtract iterations, then a single
// fix-up cycle restores the signs of quotient and remainder for DIV.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ZERO = 2'd1,
    S_DIV_ON   = 2'd2,
    S_DIV_END  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [DATA_W-1:0]   r_divisor;
  logic [DATA_W-1:0]   r_rem;
  logic                r_q_neg;
  logic                r_r_neg;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_start;
  logic                w_op1_neg;
  logic                w_op2_neg;
  logic [DATA_W-1:0]   w_op1_abs;
  logic [DATA_W-1:0]   w_op2_abs;
  logic [DATA_W-1:0]   w_shift_lo;
  logic [DATA_W:0]     w_sub;
  logic                w_fits;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  assign w_start   = bus.start_i & ~bus.annul_i;
  assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign w_op1_abs = w_op1_neg ? (~bus.opdata1_i + ONE) : bus.opdata1_i;
  assign w_op2_abs = w_op2_neg ? (~bus.opdata2_i + ONE) : bus.opdata2_i;

  // One restoring step. The shifted partial remainder is DATA_W+1 bits wide; its
  // top bit is r_rem's MSB. If that bit is set the value already exceeds any
  // divisor, and the low DATA_W bits of the modular difference are exact.
  assign w_shift_lo = {r_rem[DATA_W-2:0], r_dividend[DATA_W-1]};
  assign w_sub      = {1'b0, w_shift_lo} - {1'b0, r_divisor};
  assign w_fits     = r_rem[DATA_W-1] | ~w_sub[DATA_W];
  assign w_rem_next = w_fits ? w_sub[DATA_W-1:0] : w_shift_lo;

  // Two's-complement sign restoration applied once after the last iteration.
  assign w_quot_fix = r_q_neg ? (~r_dividend + ONE) : r_dividend;
  assign w_rem_fix  = r_r_neg ? (~r_rem + ONE) : r_rem;

  // Stall drops in the DIV_END cycle so the pipeline advances with the result.
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~r_ready;
  assign bus.ready_o    = r_ready;
  assign bus.result_o   = r_result;
  assign bus.state_o    = r_state;

  // Controller FSM with datapath registers; annul wins over every busy transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else if (bus.annul_i && (r_state != S_IDLE)) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (w_start) begin
            r_cnt      <= '0;
            r_dividend <= w_op1_abs;
            r_divisor  <= w_op2_abs;
            r_rem      <= '0;
            r_q_neg    <= w_op1_neg ^ w_op2_neg;
            r_r_neg    <= w_op1_neg;
            r_state    <= (bus.opdata2_i == '0) ? S_DIV_ZERO : S_DIV_ON;
          end
        end
        S_DIV_ZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_DIV_END;
        end
        S_DIV_ON: begin
          if (r_cnt != CNT_LAST) begin
            r_rem      <= w_rem_next;
            r_dividend <= {r_dividend[DATA_W-2:0], w_fits};
            r_cnt      <= r_cnt + 1'b1;
          end else begin
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= 1'b1;
            r_state  <= S_DIV_END;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases from the divider's contract,
// randomized divides against an arithmetic reference model, annul/reset and
// back-to-back sequencing.
module tb_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_seq_if #(.DATA_W(W)) bus();

  div_seq #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;
  logic [2*W-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: divide magnitudes with plain arithmetic, quotient truncates toward
  // zero, remainder takes the dividend's sign; divide by zero yields 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] ua, ub, q, r;
    logic an, bn;
    if (b == 32'd0) return 64'd0;
    an = sgn & a[31];
    bn = sgn & b[31];
    ua = an ? (32'd0 - a) : a;
    ub = bn ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (an ^ bn) q = 32'd0 - q;
    if (an)      r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    #1;
    check("stall_at_T", 64'(bus.stallreq_o), 64'd1);
  endtask

  // Waits for ready_o, checking stall in every busy cycle; n = cycles waited or -1.
  task automatic wait_ready(input string tag, input bit scramble, output int n);
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (bus.ready_o === 1'b1) begin
        n = c;
        break;
      end
      check({tag, " stall_busy"}, 64'(bus.stallreq_o), 64'd1);
      if (scramble) begin
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end
    end
    if (n > 0) begin
      check({tag, " stall_end"}, 64'(bus.stallreq_o), 64'd0);
      check({tag, " sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check({tag, " result"}, bus.result_o, exp_q.pop_front());
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp_res, input bit scramble);
    int n;
    exp_q.push_back(exp_res);
    start_op(a, b, sgn);
    wait_ready(tag, scramble, n);
    check({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
    bus.start_i = 1'b0;
    tick();
    check({tag, " ready_one_cycle"}, 64'(bus.ready_o), 64'd0);
    check({tag, " back_idle"}, 64'(bus.state_o), 64'd0);
  endtask

  // Directed and random stimulus
  initial begin
    int n1, n2, pulses;
    logic [31:0] ra, rb;
    logic rs;

    bus.start_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.annul_i      = 1'b0;

    // Reset: outputs observed before any clock edge while reset is high
    #2 rst = 1'b1;
    #1;
    check("reset result", bus.result_o, 64'd0);
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset state", 64'(bus.state_o), 64'd0);
    check("reset stall", 64'(bus.stallreq_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed cases
    run_div("udiv_100_7",  32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                1'b1);
    run_div("sdiv_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    run_div("sdiv_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b1);
    run_div("udiv_zero",   32'd1234,       32'd0,          1'b0, 64'd0,                          1'b0);
    run_div("sdiv_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0, 32'h8000_0000},         1'b1);
    run_div("udiv_big",    32'hFFFF_FFFF,  32'h8000_0001,  1'b0, {32'h7FFF_FFFE, 32'd1},         1'b1);

    // Randomized divides against the reference model
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rs = 1'($urandom_range(0, 1));
      run_div("rand", ra, rb, rs, model(ra, rb, rs), 1'b1);
    end

    // Annul mid-divide: result must clear, no ready pulse follows
    run_div("pre_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);
    start_op(32'd9, 32'd3, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    bus.annul_i = 1'b1;
    #1;
    check("annul stall_masked", 64'(bus.stallreq_o), 64'd0);
    tick();
    check("annul state", 64'(bus.state_o), 64'd0);
    check("annul ready", 64'(bus.ready_o), 64'd0);
    check("annul result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ready_o === 1'b1) pulses++;
    end
    check("annul no_ready", 64'(pulses), 64'd0);

    // Annul in IDLE blocks the start
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    tick();
    check("annul_idle state1", 64'(bus.state_o), 64'd0);
    tick();
    check("annul_idle state2", 64'(bus.state_o), 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Async reset mid-DIV_ON clears outputs without a clock edge
    run_div("pre_reset", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);
    start_op(32'd50, 32'd5, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    check("pre_reset busy", 64'(bus.state_o), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst result", bus.result_o, 64'd0);
    check("async_rst ready", 64'(bus.ready_o), 64'd0);
    check("async_rst state", 64'(bus.state_o), 64'd0);
    bus.start_i = 1'b0;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ready_o === 1'b1) pulses++;
    end
    check("async_rst no_ready", 64'(pulses), 64'd0);

    // Back-to-back with start held high; operands change after the first ready
    exp_q.push_back({32'd2, 32'd14});
    start_op(32'd100, 32'd7, 1'b0);
    wait_ready("b2b_first", 1'b0, n1);
    check("b2b_first latency", 64'(n1), 64'd34);
    exp_q.push_back({32'd0, 32'd3});
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    wait_ready("b2b_second", 1'b0, n2);
    check("b2b spacing", 64'(n2), 64'd35);
    bus.start_i = 1'b0;
    tick();
    check("b2b ready_one_cycle", 64'(bus.ready_o), 64'd0);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
